busmatrix_op_rr_arb: RTL and testbench

Round-robin arbiter for one bus-matrix output stage. It selects which input port owns the shared slave's address phase. It drives addr_in_port/no_port into the output-stage address and data muxes. It holds the grant for the whole of a fixed-length burst, an undefined-length INCR burst and a locked sequence, so transfers are never split between masters.

---
 rtl/busmatrix_pkg.sv | 41 ++++
 rtl/busmatrix_op_rr_arb_if.sv | 38 +++
 rtl/busmatrix_rr_pick.sv | 35 +++
 rtl/busmatrix_op_rr_arb.sv | 100 ++++++++++
 tb/tb_busmatrix_op_rr_arb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/busmatrix_pkg.sv
// Shared definitions for the bus-matrix output stages.
//   - AHB HTRANS / HBURST encodings
//   - Arbiter state enum
//   - burst_beats(): number of beats after the first one in a fixed-length burst
package busmatrix_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_LOCK  = 2'd2
  } arb_state_e;

  // len-1 for fixed-length bursts, 0 for SINGLE and undefined-length INCR.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    case (hburst_e'(hburst))
      BURST_WRAP4,  BURST_INCR4:  return 4'd3;
      BURST_WRAP8,  BURST_INCR8:  return 4'd7;
      BURST_WRAP16, BURST_INCR16: return 4'd15;
      default:                    return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/busmatrix_op_rr_arb_if.sv
// Arbiter-side bundle of one bus-matrix output stage.
//   req_port     per-port request from the input stages
//   HREADYM      output-stage HREADYMUX (arbitration advances only when 1)
//   HSELM        HSEL of the currently muxed port
//   HTRANSM      HTRANS of the currently muxed port
//   HBURSTM      HBURST of the currently muxed port
//   HMASTLOCKM   masked HMASTLOCK of the muxed port
//   addr_in_port granted port index (registered)
//   no_port      1 = no port granted (registered)
//   arb_state    current arbiter state, for observation
// Modport master = input-stage/mux side, slave = arbiter side.
interface busmatrix_op_rr_arb_if #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 3
) ();
  import busmatrix_pkg::*;

  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;
  arb_state_e           arb_state;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, arb_state
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, arb_state
  );

endinterface

// File: rtl/busmatrix_rr_pick.sv
// Combinational rotating-priority picker.
//   req   : request vector
//   ptr   : index of the last granted port (lowest priority)
//   grant : first requesting index scanning ptr+1, ptr+2, ... modulo NUM_PORTS
//   valid : at least one request present
module busmatrix_rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [PORT_W-1:0]    grant,
  output logic                 valid
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  int unsigned idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    // i = NUM_PORTS lands back on ptr itself, so the owner is re-granted
    // only when nobody else asks.
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = (32'(ptr) + i) % NUM_PORTS;
      if (!valid && req[IW'(idx)]) begin
        valid = 1'b1;
        grant = PORT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/busmatrix_op_rr_arb.sv
// Round-robin arbiter for one bus-matrix output stage.
// Chooses which input port owns the shared slave's address phase and keeps
// that grant across fixed-length bursts, undefined-length INCR bursts and
// locked sequences.
//   HCLK    : clock
//   HRESETn : synchronous active-low reset
//   bus     : arbiter side of busmatrix_op_rr_arb_if (requests, muxed
//             HSEL/HTRANS/HBURST/HMASTLOCK/HREADY in; addr_in_port,
//             no_port, arb_state out)
module busmatrix_op_rr_arb
  import busmatrix_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 3
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  busmatrix_op_rr_arb_if.slave   bus
);

  if ((2 ** PORT_W) < NUM_PORTS) begin : g_bad_width
    $error("PORT_W too narrow for NUM_PORTS");
  end

  logic [3:0]        cnt_q, cnt_next;
  logic [PORT_W-1:0] ptr_q;
  logic [PORT_W-1:0] addr_q;
  logic              no_port_q;
  arb_state_e        state_q;
  logic              hold;
  logic              seq_or_busy;
  logic [PORT_W-1:0] pick_idx;
  logic              pick_valid;
  htrans_e           trans;

  assign trans = htrans_e'(bus.HTRANSM);

  busmatrix_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req   (bus.req_port),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  // Beat counter: a NONSEQ either starts a fixed burst or terminates
  // whatever was running (SINGLE/INCR/deselected start).
  always_comb begin
    cnt_next = cnt_q;
    case (trans)
      TRANS_NONSEQ: cnt_next = bus.HSELM ? burst_beats(bus.HBURSTM) : 4'd0;
      TRANS_SEQ:    if (cnt_q != 4'd0) cnt_next = cnt_q - 4'd1;
      TRANS_BUSY:   cnt_next = cnt_q;
      default:      cnt_next = 4'd0;
    endcase
  end

  assign seq_or_busy = (trans == TRANS_SEQ) || (trans == TRANS_BUSY);

  assign hold = (cnt_next != 4'd0)
              | bus.HMASTLOCKM
              | (bus.HSELM & (bus.HBURSTM == BURST_INCR) & seq_or_busy)
              | (bus.HSELM & (trans == TRANS_BUSY));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= ST_ARB;
      cnt_q     <= '0;
      ptr_q     <= PORT_W'(NUM_PORTS - 1);
      addr_q    <= '0;
      no_port_q <= 1'b1;
    end else if (bus.HREADYM) begin
      cnt_q <= cnt_next;
      if (bus.HMASTLOCKM)
        state_q <= ST_LOCK;
      else if (hold)
        state_q <= ST_BURST;
      else
        state_q <= ST_ARB;

      if (hold) begin
        // Owner keeps the bus even if its own request has dropped.
        no_port_q <= 1'b0;
      end else if (pick_valid) begin
        addr_q    <= pick_idx;
        ptr_q     <= pick_idx;
        no_port_q <= 1'b0;
      end else begin
        no_port_q <= 1'b1;
      end
    end
  end

  assign bus.addr_in_port = addr_q;
  assign bus.no_port      = no_port_q;
  assign bus.arb_state    = state_q;

endmodule

// File: tb/tb_busmatrix_op_rr_arb.sv
// Self-checking bench for busmatrix_op_rr_arb (NUM_PORTS=2, PORT_W=3).
// Each row of a scenario drives the muxed bus signals for one cycle and
// queues the grant/state that must appear after the following edge.
module tb_busmatrix_op_rr_arb;
  import busmatrix_pkg::*;

  typedef struct {
    logic       rstn;
    logic [1:0] req;
    logic       rdy;
    logic       sel;
    htrans_e    trans;
    hburst_e    burst;
    logic       lock;
    logic [2:0] ex_addr;
    logic       ex_no;
    arb_state_e ex_st;
  } stim_t;

  typedef struct {
    logic [2:0] addr;
    logic       no;
    arb_state_e st;
    string      tag;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  busmatrix_op_rr_arb_if #(.NUM_PORTS(2), .PORT_W(3)) bus ();

  busmatrix_op_rr_arb #(.NUM_PORTS(2), .PORT_W(3)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  function automatic stim_t mk(input logic rstn, input logic [1:0] req,
                               input logic rdy, input logic sel,
                               input htrans_e trans, input hburst_e burst,
                               input logic lock, input logic [2:0] ex_addr,
                               input logic ex_no, input arb_state_e ex_st);
    stim_t s;
    s.rstn = rstn; s.req = req; s.rdy = rdy; s.sel = sel; s.trans = trans;
    s.burst = burst; s.lock = lock; s.ex_addr = ex_addr; s.ex_no = ex_no;
    s.ex_st = ex_st;
    return s;
  endfunction

  // Drive one cycle, queue its expectation, optionally glitch reset between
  // edges, then advance to just after the next rising edge.
  task automatic apply(input stim_t s, input string tag, input bit glitch);
    exp_t e;
    HRESETn        = s.rstn;
    bus.req_port   = s.req;
    bus.HREADYM    = s.rdy;
    bus.HSELM      = s.sel;
    bus.HTRANSM    = s.trans;
    bus.HBURSTM    = s.burst;
    bus.HMASTLOCKM = s.lock;
    e.addr = s.ex_addr; e.no = s.ex_no; e.st = s.ex_st; e.tag = tag;
    exp_q.push_back(e);
    if (glitch) begin
      #2 HRESETn = 1'b0;
      #2 HRESETn = 1'b1;
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd0, 1'b1, ST_ARB));
    s.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, TRANS_NONSEQ, BURST_INCR4, 1'b1, 3'd0, 1'b1, ST_ARB));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], $sformatf("reset[%0d]", i), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.addr_in_port !== e.addr || bus.no_port !== e.no || bus.arb_state !== e.st) begin
        errors++;
        $display("FAIL %s: got addr_in_port=%0d no_port=%b state=%s, want addr_in_port=%0d no_port=%b state=%s",
                 e.tag, bus.addr_in_port, bus.no_port, bus.arb_state.name(), e.addr, e.no, e.st.name());
      end
    end
  endtask

  task automatic test_alternation();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd0, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd1, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd0, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd1, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd1, 1'b1, ST_ARB));
    s.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd0, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd0, 1'b0, ST_ARB));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], $sformatf("alternation[%0d]", i), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.addr_in_port !== e.addr || bus.no_port !== e.no || bus.arb_state !== e.st) begin
        errors++;
        $display("FAIL %s: got addr_in_port=%0d no_port=%b state=%s, want addr_in_port=%0d no_port=%b state=%s",
                 e.tag, bus.addr_in_port, bus.no_port, bus.arb_state.name(), e.addr, e.no, e.st.name());
      end
    end
  endtask

  task automatic test_incr8_hold();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd1, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_NONSEQ, BURST_INCR8, 1'b0, 3'd1, 1'b0, ST_BURST));
    for (int k = 0; k < 6; k++)
      s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR8, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR8, 1'b0, 3'd0, 1'b0, ST_ARB));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], $sformatf("incr8[%0d]", i), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.addr_in_port !== e.addr || bus.no_port !== e.no || bus.arb_state !== e.st) begin
        errors++;
        $display("FAIL %s: got addr_in_port=%0d no_port=%b state=%s, want addr_in_port=%0d no_port=%b state=%s",
                 e.tag, bus.addr_in_port, bus.no_port, bus.arb_state.name(), e.addr, e.no, e.st.name());
      end
    end
  endtask

  task automatic test_stall();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd1, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_NONSEQ, BURST_INCR4, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR4, 1'b0, 3'd1, 1'b0, ST_BURST));
    for (int k = 0; k < 3; k++)
      s.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR4, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR4, 1'b0, 3'd0, 1'b0, ST_ARB));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], $sformatf("stall[%0d]", i), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.addr_in_port !== e.addr || bus.no_port !== e.no || bus.arb_state !== e.st) begin
        errors++;
        $display("FAIL %s: got addr_in_port=%0d no_port=%b state=%s, want addr_in_port=%0d no_port=%b state=%s",
                 e.tag, bus.addr_in_port, bus.no_port, bus.arb_state.name(), e.addr, e.no, e.st.name());
      end
    end
  endtask

  task automatic test_lock();
    stim_t s[$];
    exp_t  e;
    for (int k = 0; k < 5; k++)
      s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, (k % 2 == 0) ? TRANS_NONSEQ : TRANS_IDLE,
                     BURST_SINGLE, 1'b1, 3'd0, 1'b0, ST_LOCK));
    s.push_back(mk(1'b1, 2'b11, 1'b0, 1'b1, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd0, 1'b0, ST_LOCK));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd1, 1'b0, ST_ARB));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], $sformatf("lock[%0d]", i), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.addr_in_port !== e.addr || bus.no_port !== e.no || bus.arb_state !== e.st) begin
        errors++;
        $display("FAIL %s: got addr_in_port=%0d no_port=%b state=%s, want addr_in_port=%0d no_port=%b state=%s",
                 e.tag, bus.addr_in_port, bus.no_port, bus.arb_state.name(), e.addr, e.no, e.st.name());
      end
    end
  endtask

  task automatic test_wrap8_abort();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_NONSEQ, BURST_WRAP8, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_WRAP8, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_WRAP8, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_IDLE, BURST_WRAP8, 1'b0, 3'd0, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd0, 1'b1, ST_ARB));
    s.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, TRANS_IDLE, BURST_SINGLE, 1'b0, 3'd0, 1'b1, ST_ARB));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], $sformatf("wrap8_abort[%0d]", i), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.addr_in_port !== e.addr || bus.no_port !== e.no || bus.arb_state !== e.st) begin
        errors++;
        $display("FAIL %s: got addr_in_port=%0d no_port=%b state=%s, want addr_in_port=%0d no_port=%b state=%s",
                 e.tag, bus.addr_in_port, bus.no_port, bus.arb_state.name(), e.addr, e.no, e.st.name());
      end
    end
  endtask

  task automatic test_incr_busy();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, 2'b01, 1'b1, 1'b1, TRANS_NONSEQ, BURST_INCR, 1'b0, 3'd0, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR, 1'b0, 3'd0, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b10, 1'b1, 1'b1, TRANS_BUSY, BURST_INCR, 1'b0, 3'd0, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR, 1'b0, 3'd0, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_IDLE, BURST_INCR, 1'b0, 3'd1, 1'b0, ST_ARB));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], $sformatf("incr_busy[%0d]", i), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.addr_in_port !== e.addr || bus.no_port !== e.no || bus.arb_state !== e.st) begin
        errors++;
        $display("FAIL %s: got addr_in_port=%0d no_port=%b state=%s, want addr_in_port=%0d no_port=%b state=%s",
                 e.tag, bus.addr_in_port, bus.no_port, bus.arb_state.name(), e.addr, e.no, e.st.name());
      end
    end
  endtask

  task automatic test_lock_last_beat();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_NONSEQ, BURST_INCR4, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR4, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR4, 1'b0, 3'd1, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_INCR4, 1'b1, 3'd1, 1'b0, ST_LOCK));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_NONSEQ, BURST_SINGLE, 1'b0, 3'd0, 1'b0, ST_ARB));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], $sformatf("lock_last_beat[%0d]", i), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (bus.addr_in_port !== e.addr || bus.no_port !== e.no || bus.arb_state !== e.st) begin
        errors++;
        $display("FAIL %s: got addr_in_port=%0d no_port=%b state=%s, want addr_in_port=%0d no_port=%b state=%s",
                 e.tag, bus.addr_in_port, bus.no_port, bus.arb_state.name(), e.addr, e.no, e.st.name());
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_NONSEQ, BURST_WRAP16, 1'b0, 3'd0, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_WRAP16, 1'b0, 3'd0, 1'b0, ST_BURST));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_WRAP16, 1'b0, 3'd0, 1'b0, ST_BURST));
    s.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_WRAP16, 1'b0, 3'd0, 1'b1, ST_ARB));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_WRAP16, 1'b0, 3'd0, 1'b0, ST_ARB));
    s.push_back(mk(1'b1, 2'b11, 1'b1, 1'b1, TRANS_SEQ, BURST_WRAP16, 1'b0, 3'd1, 1'b0, ST_ARB));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], $sformatf("reset_mid_burst[%0d]", i), (i == 2));
      e = exp_q.pop_front();
      checks++;
      if (bus.addr_in_port !== e.addr || bus.no_port !== e.no || bus.arb_state !== e.st) begin
        errors++;
        $display("FAIL %s: got addr_in_port=%0d no_port=%b state=%s, want addr_in_port=%0d no_port=%b state=%s",
                 e.tag, bus.addr_in_port, bus.no_port, bus.arb_state.name(), e.addr, e.no, e.st.name());
      end
    end
  endtask

  initial begin
    HCLK           = 1'b0;
    HRESETn        = 1'b0;
    bus.req_port   = '0;
    bus.HREADYM    = 1'b1;
    bus.HSELM      = 1'b0;
    bus.HTRANSM    = TRANS_IDLE;
    bus.HBURSTM    = BURST_SINGLE;
    bus.HMASTLOCKM = 1'b0;
    errors         = 0;
    checks         = 0;
    #1;
    test_reset();
    test_alternation();
    test_incr8_hold();
    test_stall();
    test_lock();
    test_wrap8_abort();
    test_incr_busy();
    test_lock_last_beat();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
